rr_encoder_arbiter: RTL

- Shares one downstream resource (e.g. a single encoder/datapath slot) between 8 requesters.
- Each cycle it selects at most one owner, in round-robin or fixed-priority mode.
- Drives a one-hot grant plus the 3-bit encoded owner index, as an 8-to-3 encoder would.
- Holds the grant while the owner keeps requesting, up to a configurable hold limit; then it forces re-arbitration.

---
 rtl/rr_encoder_arbiter_if.sv | 48 ++++
 rtl/rr_encoder_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rr_encoder_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_encoder_arbiter_if
//
// Bundles the request/grant signals of the 8-way round-robin / fixed-priority
// arbiter so the requester side and the arbiter side connect through one port.
//
// Signals:
//   req        requester -> arbiter  request vector, bit i = requester i
//   rr_en      requester -> arbiter  1 = round-robin, 0 = fixed priority
//   gnt        arbiter -> requester  one-hot grant (registered)
//   gnt_idx    arbiter -> requester  encoded owner index (registered)
//   gnt_valid  arbiter -> requester  high while gnt is nonzero
//   hold_cnt   arbiter -> requester  cycles the owner has held the grant, minus 1
//
// Modports:
//   master  the requester side (drives req / rr_en)
//   slave   the arbiter side (drives the grant outputs)
// -----------------------------------------------------------------------------
interface rr_encoder_arbiter_if #(
    parameter int N      = 8,
    parameter int IDX_W  = 3,
    parameter int HOLD_W = 4
);
    logic [N-1:0]      req;
    logic              rr_en;
    logic [N-1:0]      gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_valid;
    logic [HOLD_W-1:0] hold_cnt;

    modport master (
        output req,
        output rr_en,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  hold_cnt
    );

    modport slave (
        input  req,
        input  rr_en,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output hold_cnt
    );
endinterface

// File: rtl/rr_encoder_arbiter.sv
// -----------------------------------------------------------------------------
// rr_encoder_arbiter
//
// Shares one downstream resource between N (=8) requesters. At most one owner
// is granted at a time, chosen either round-robin (starting at rr_ptr) or by
// fixed priority (bit N-1 highest). The owner keeps the grant while it keeps
// requesting, up to MAX_HOLD consecutive cycles (0 = unlimited); on release or
// expiry the arbiter re-arbitrates in the same edge so there is no bubble.
//
// Ports:
//   clk   input  system clock, rising edge
//   rst   input  asynchronous, active-high reset
//   bus   slave modport of rr_encoder_arbiter_if:
//           req, rr_en                         (inputs)
//           gnt, gnt_idx, gnt_valid, hold_cnt  (registered outputs)
// -----------------------------------------------------------------------------
module rr_encoder_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_encoder_arbiter_if.slave   bus
);

    localparam int HOLD_W = 4;
    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;
    // Value of hold_cnt on the owner's last permitted cycle.
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Arbitration result: winner flag plus encoded index.
    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } win_t;

    state_t            state, state_n;
    logic [IDX_W-1:0]  rr_ptr, rr_ptr_n;
    logic [N-1:0]      gnt_r, gnt_n;
    logic [IDX_W-1:0]  idx_r, idx_n;
    logic              vld_r, vld_n;
    logic [HOLD_W-1:0] hold_r, hold_n;

    logic              released;
    logic              expired;
    logic              rearb;
    logic [IDX_W-1:0]  arb_ptr;
    win_t              win;

    // -------------------------------------------------------------------------
    // Round-robin search: first set bit at ptr, ptr+1, ... modulo N.
    // N is a power of two, so the IDX_W-bit add wraps naturally.
    // -------------------------------------------------------------------------
    function automatic win_t arb_rr(input logic [N-1:0] r,
                                    input logic [IDX_W-1:0] ptr);
        win_t             res;
        logic [IDX_W-1:0] cand;
        res = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr + IDX_W'(k);
            if (!res.found && r[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Fixed priority: highest set bit wins (ascending scan, last hit kept).
    // -------------------------------------------------------------------------
    function automatic win_t arb_fixed(input logic [N-1:0] r);
        win_t res;
        res = '0;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                res.found = 1'b1;
                res.idx   = IDX_W'(i);
            end
        end
        return res;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
        return N'(1) << idx;
    endfunction

    // -------------------------------------------------------------------------
    // Next-state / next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        gnt_n    = gnt_r;
        idx_n    = idx_r;
        vld_n    = vld_r;
        hold_n   = hold_r;
        released = 1'b0;
        expired  = 1'b0;
        rearb    = 1'b0;
        arb_ptr  = rr_ptr;
        win      = '0;

        case (state)
            IDLE: begin
                rearb = 1'b1;
            end
            GRANT: begin
                released = !bus.req[idx_r];
                expired  = (MAX_HOLD != 0) && (hold_r == HOLD_LAST);
                if (released || expired) begin
                    // Pointer advances past the outgoing owner in both modes,
                    // and the same-edge re-arbitration already uses it.
                    rr_ptr_n = idx_r + IDX_W'(1);
                    arb_ptr  = rr_ptr_n;
                    rearb    = 1'b1;
                end else if (hold_r != HOLD_SAT) begin
                    hold_n = hold_r + HOLD_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (rearb) begin
            // rr_en only matters at arbitration time; an established owner is
            // never affected by a mode change.
            win = bus.rr_en ? arb_rr(bus.req, arb_ptr) : arb_fixed(bus.req);
            if (win.found) begin
                state_n = GRANT;
                gnt_n   = onehot(win.idx);
                idx_n   = win.idx;
                vld_n   = 1'b1;
                hold_n  = '0;
            end else begin
                state_n = IDLE;
                gnt_n   = '0;
                idx_n   = '0;
                vld_n   = 1'b0;
                hold_n  = '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            gnt_r  <= '0;
            idx_r  <= '0;
            vld_r  <= 1'b0;
            hold_r <= '0;
        end else begin
            state  <= state_n;
            rr_ptr <= rr_ptr_n;
            gnt_r  <= gnt_n;
            idx_r  <= idx_n;
            vld_r  <= vld_n;
            hold_r <= hold_n;
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_idx   = idx_r;
    assign bus.gnt_valid = vld_r;
    assign bus.hold_cnt  = hold_r;

endmodule
